// File: rtl/calc_bcd_display_if.sv
// Operand/key inputs and display/status outputs of the BCD calculator.
// The master side drives switches and keys; the slave side is the calculator.
interface calc_bcd_display_if #(
    parameter int W      = 5,
    parameter int DIGITS = 4
);
    logic [2*W-1:0]      SW;
    logic [3:0]          KEY;
    logic [2*W:0]        LEDR;
    logic [7*DIGITS-1:0] HEX;
    logic                BUSY;
    logic                OVF;

    modport master (
        output SW, KEY,
        input  LEDR, HEX, BUSY, OVF
    );

    modport slave (
        input  SW, KEY,
        output LEDR, HEX, BUSY, OVF
    );
endinterface

// File: rtl/calc_bcd_display.sv
// Key-driven add/sub/mul/clear calculator with a sequential double-dabble
// converter feeding sign-aware, zero-blanked seven-segment digits.
module calc_bcd_display #(
    parameter int W      = 5,
    parameter int DIGITS = 4
) (
    input  logic              CLOCK_50,
    input  logic              RST,
    calc_bcd_display_if.slave bus
);

    localparam int RW = 2 * W;
    localparam int BW = 4 * DIGITS;
    localparam int HW = 7 * DIGITS;
    localparam int CW = $clog2(RW + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // The minus sign costs one digit position, hence the smaller negative limit.
    localparam logic [63:0] LIMIT_POS = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] LIMIT_NEG = pow10(DIGITS - 1) - 64'd1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [HW-1:0] HEX_RST = {{(7 * (DIGITS - 1)){1'b1}}, 7'b1000000};

    typedef enum logic [1:0] {IDLE, LOAD, CONV, SHOW} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_CLR} op_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    state_t          state;
    op_t             op_r;
    op_t             op_sel;

    logic [3:0]      key_s1;
    logic [3:0]      key_s2;
    logic [3:0]      key_prev;
    logic [3:0]      key_armed;
    logic [1:0]      settle;
    logic            settled;
    logic [3:0]      press;

    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [RW-1:0]   a_ext;
    logic [RW-1:0]   b_ext;
    logic [RW-1:0]   mag_n;
    logic            sign_n;
    logic            ovf_n;

    logic [RW-1:0]   mag_r;
    logic            sign_r;
    logic            ovf_r;
    logic [RW-1:0]   bin_r;
    logic [BW-1:0]   bcd_r;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_step;
    logic [CW-1:0]   cnt_r;

    logic [HW-1:0]   hex_n;
    logic [RW:0]     ledr_r;
    logic [HW-1:0]   hex_r;
    logic            busy_r;
    logic            ovf_out;

    // Edge detection waits until the synchroniser holds real samples, and a key
    // only arms once it has been seen released, so a key held through reset is inert.
    assign settled = (settle == 2'd2);
    assign press   = key_armed & key_prev & ~key_s2 & {4{settled}};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        op_sel = OP_ADD;
        if (press[0])      op_sel = OP_ADD;
        else if (press[1]) op_sel = OP_SUB;
        else if (press[2]) op_sel = OP_MUL;
        else if (press[3]) op_sel = OP_CLR;
    end

    assign a_ext = RW'(a_r);
    assign b_ext = RW'(b_r);

    always_comb begin
        mag_n  = '0;
        sign_n = 1'b0;
        case (op_r)
            OP_ADD: mag_n = a_ext + b_ext;
            OP_SUB: begin
                if (a_r < b_r) begin
                    mag_n  = b_ext - a_ext;
                    sign_n = 1'b1;
                end else begin
                    mag_n  = a_ext - b_ext;
                end
            end
            OP_MUL:  mag_n = a_ext * b_ext;
            default: mag_n = '0;
        endcase
        if (mag_n == '0) sign_n = 1'b0;
        ovf_n = sign_n ? (64'(mag_n) > LIMIT_NEG) : (64'(mag_n) > LIMIT_POS);
    end

    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_step = {bcd_adj[BW-2:0], bin_r[RW-1]};

    always_comb begin
        int msd;
        msd   = 0;
        hex_n = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_r)                          hex_n[7*i +: 7] = SEG_E;
            else if (i <= msd)                  hex_n[7*i +: 7] = seg7(bcd_r[4*i +: 4]);
            else if (sign_r && (i == msd + 1))  hex_n[7*i +: 7] = SEG_MINUS;
            else                                hex_n[7*i +: 7] = SEG_BLANK;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state     <= IDLE;
            key_s1    <= '1;
            key_s2    <= '1;
            key_prev  <= '1;
            key_armed <= '0;
            settle    <= '0;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= OP_ADD;
            mag_r     <= '0;
            sign_r    <= 1'b0;
            ovf_r     <= 1'b0;
            bin_r     <= '0;
            bcd_r     <= '0;
            cnt_r     <= '0;
            ledr_r    <= '0;
            hex_r     <= HEX_RST;
            busy_r    <= 1'b0;
            ovf_out   <= 1'b0;
        end else begin
            key_s1    <= bus.KEY;
            key_s2    <= key_s1;
            key_prev  <= key_s2;
            key_armed <= key_armed | ({4{settled}} & key_s2);
            if (!settled) settle <= settle + 2'd1;

            case (state)
                IDLE: begin
                    if (|press) begin
                        a_r    <= bus.SW[RW-1:W];
                        b_r    <= bus.SW[W-1:0];
                        op_r   <= op_sel;
                        busy_r <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    mag_r  <= mag_n;
                    sign_r <= sign_n;
                    ovf_r  <= ovf_n;
                    bin_r  <= mag_n;
                    bcd_r  <= '0;
                    cnt_r  <= '0;
                    state  <= CONV;
                end
                CONV: begin
                    bin_r <= {bin_r[RW-2:0], 1'b0};
                    bcd_r <= bcd_step;
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == CW'(RW - 1)) state <= SHOW;
                end
                SHOW: begin
                    ledr_r  <= {sign_r, mag_r};
                    hex_r   <= hex_n;
                    ovf_out <= ovf_r;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.LEDR = ledr_r;
    assign bus.HEX  = hex_r;
    assign bus.BUSY = busy_r;
    assign bus.OVF  = ovf_out;

endmodule

// File: tb/tb_calc_bcd_display.sv
// Scoreboard bench for calc_bcd_display: a 4-digit and a 2-digit instance,
// directed operations with hand-computed displays, monitors checking each update.
module tb_calc_bcd_display;

    localparam logic [3:0] K_ADD = 4'b1110;
    localparam logic [3:0] K_SUB = 4'b1101;
    localparam logic [3:0] K_MUL = 4'b1011;
    localparam logic [3:0] K_CLR = 4'b0111;

    typedef struct {
        logic [10:0] ledr;
        logic [62:0] hex;
        logic        ovf;
    } exp_t;

    bit   clk = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;
    exp_t q4[$];
    exp_t q2[$];
    bit   prev4 = 1'b0;
    bit   prev2 = 1'b0;
    int   bcnt4 = 0;
    int   bcnt2 = 0;

    calc_bcd_display_if #(.W(5), .DIGITS(4)) if4 ();
    calc_bcd_display_if #(.W(5), .DIGITS(2)) if2 ();

    calc_bcd_display #(.W(5), .DIGITS(4)) dut4 (.CLOCK_50(clk), .RST(RST), .bus(if4.slave));
    calc_bcd_display #(.W(5), .DIGITS(2)) dut2 (.CLOCK_50(clk), .RST(RST), .bus(if2.slave));

    always #5 clk = ~clk;

    function automatic logic [62:0] seg_str(input string s);
        logic [62:0] r;
        logic [6:0]  g;
        int          n;
        r = '1;
        n = s.len();
        for (int i = 0; i < n && i < 9; i++) begin
            case (s[n-1-i])
                "0":     g = 7'b1000000;
                "1":     g = 7'b1111001;
                "2":     g = 7'b0100100;
                "3":     g = 7'b0110000;
                "4":     g = 7'b0011001;
                "5":     g = 7'b0010010;
                "6":     g = 7'b0000010;
                "7":     g = 7'b1111000;
                "8":     g = 7'b0000000;
                "9":     g = 7'b0010000;
                "-":     g = 7'b0111111;
                "E":     g = 7'b0000110;
                default: g = 7'b1111111;
            endcase
            r[7*i +: 7] = g;
        end
        return r;
    endfunction

    function automatic logic [62:0] dmask(input int n);
        return (63'd1 << (7 * n)) - 63'd1;
    endfunction

    function automatic exp_t mk(input logic [10:0] ledr, input string disp, input logic ovf);
        exp_t e;
        e.ledr = ledr;
        e.hex  = seg_str(disp);
        e.ovf  = ovf;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input int n, input logic [10:0] ledr,
                           input logic [62:0] hex, input logic ovf, input int bc);
        check({tag, "_ledr"}, 64'(ledr), 64'(e.ledr));
        check({tag, "_hex"}, 64'(hex & dmask(n)), 64'(e.hex & dmask(n)));
        check({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
        check({tag, "_busy_cycles"}, 64'(bc), 64'd12);
    endtask

    task automatic check_reset(input string tag, input int n, input logic [10:0] ledr,
                               input logic [62:0] hex, input logic busy, input logic ovf);
        check({tag, "_rst_ledr"}, 64'(ledr), 64'd0);
        check({tag, "_rst_hex"}, 64'(hex & dmask(n)), 64'(seg_str("0") & dmask(n)));
        check({tag, "_rst_busy"}, 64'(busy), 64'd0);
        check({tag, "_rst_ovf"}, 64'(ovf), 64'd0);
    endtask

    always @(negedge clk) begin : mon4
        exp_t e;
        if (RST) bcnt4 = 0;
        else if (if4.BUSY) bcnt4++;
        else if (prev4) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d4_update: got unexpected display update, expected none");
            end else begin
                e = q4.pop_front();
                compare("d4", e, 4, if4.LEDR, 63'(if4.HEX), if4.OVF, bcnt4);
            end
            bcnt4 = 0;
        end
        prev4 = if4.BUSY;
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (RST) bcnt2 = 0;
        else if (if2.BUSY) bcnt2++;
        else if (prev2) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d2_update: got unexpected display update, expected none");
            end else begin
                e = q2.pop_front();
                compare("d2", e, 2, if2.LEDR, 63'(if2.HEX), if2.OVF, bcnt2);
            end
            bcnt2 = 0;
        end
        prev2 = if2.BUSY;
    end

    task automatic wait_busy(input int d);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if ((d == 4) ? if4.BUSY : if2.BUSY) return;
        end
        checks++;
        failures++;
        $display("FAIL d%0d_busy_rise: got no BUSY within 20 cycles, expected BUSY", d);
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (d == 4 && q4.size() == 0 && !if4.BUSY) begin
                repeat (3) @(posedge clk);
                #1;
                return;
            end
            if (d == 2 && q2.size() == 0 && !if2.BUSY) begin
                repeat (3) @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL d%0d_done: got no completion within 300 cycles, expected update", d);
    endtask

    task automatic op(input int d, input int a, input int b, input logic [3:0] keys, input int hold,
                      input logic [10:0] ledr, input string disp, input logic ovf);
        if (d == 4) begin
            q4.push_back(mk(ledr, disp, ovf));
            if4.SW  = {5'(a), 5'(b)};
            if4.KEY = keys;
        end else begin
            q2.push_back(mk(ledr, disp, ovf));
            if2.SW  = {5'(a), 5'(b)};
            if2.KEY = keys;
        end
        repeat (hold) @(posedge clk);
        #1;
        if (d == 4) if4.KEY = 4'hF;
        else        if2.KEY = 4'hF;
        wait_done(d);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST     = 1'b1;
        if4.SW  = '0;
        if4.KEY = 4'hF;
        if2.SW  = '0;
        if2.KEY = 4'hF;
        repeat (3) @(posedge clk);
        #1 RST = 1'b0;
        check_reset("d4", 4, if4.LEDR, 63'(if4.HEX), if4.BUSY, if4.OVF);
        check_reset("d2", 2, if2.LEDR, 63'(if2.HEX), if2.BUSY, if2.OVF);
        repeat (3) @(posedge clk);
        #1;

        // Four-digit instance: main functions and sign handling.
        op(4, 31, 31, K_MUL, 2, {1'b0, 10'd961}, " 961", 1'b0);
        op(4, 3, 20, K_SUB, 2, {1'b1, 10'd17}, " -17", 1'b0);
        op(4, 5, 5, K_SUB, 2, {1'b0, 10'd0}, "   0", 1'b0);

        // Add and mul together: add wins; a sub pressed mid-operation is dropped.
        q4.push_back(mk({1'b0, 10'd16}, "  16", 1'b0));
        if4.SW  = {5'd7, 5'd9};
        if4.KEY = K_ADD & K_MUL;
        repeat (2) @(posedge clk);
        #1 if4.KEY = 4'hF;
        wait_busy(4);
        @(posedge clk);
        #1 if4.KEY = K_SUB;
        repeat (2) @(posedge clk);
        #1 if4.KEY = 4'hF;
        wait_done(4);

        op(4, 12, 3, K_ADD, 100, {1'b0, 10'd15}, "  15", 1'b0);
        op(4, 31, 31, K_CLR, 2, {1'b0, 10'd0}, "   0", 1'b0);
        op(4, 0, 31, K_SUB, 2, {1'b1, 10'd31}, " -31", 1'b0);

        // Reset during conversion, with KEY[0] held low across reset release.
        if4.SW  = {5'd20, 5'd20};
        if4.KEY = K_MUL;
        repeat (2) @(posedge clk);
        #1 if4.KEY = 4'hF;
        wait_busy(4);
        repeat (5) @(posedge clk);
        #1;
        RST     = 1'b1;
        if4.KEY = K_ADD;
        @(posedge clk);
        #1 check_reset("d4_mid", 4, if4.LEDR, 63'(if4.HEX), if4.BUSY, if4.OVF);
        @(posedge clk);
        #1 RST = 1'b0;
        repeat (10) @(posedge clk);
        #1 if4.KEY = 4'hF;
        repeat (5) @(posedge clk);
        #1;
        op(4, 2, 3, K_MUL, 2, {1'b0, 10'd6}, "   6", 1'b0);

        // Two-digit instance: overflow limits for both signs.
        op(2, 31, 31, K_ADD, 2, {1'b0, 10'd62}, "62", 1'b0);
        op(2, 31, 31, K_MUL, 2, {1'b0, 10'd961}, "EE", 1'b1);
        op(2, 0, 20, K_SUB, 2, {1'b1, 10'd20}, "EE", 1'b1);
        op(2, 0, 9, K_SUB, 2, {1'b1, 10'd9}, "-9", 1'b0);
        op(2, 9, 11, K_MUL, 2, {1'b0, 10'd99}, "99", 1'b0);
        op(2, 10, 10, K_MUL, 2, {1'b0, 10'd100}, "EE", 1'b1);
        op(2, 0, 0, K_CLR, 2, {1'b0, 10'd0}, " 0", 1'b0);

        repeat (20) @(posedge clk);
        #1;
        check("d4_queue_left", 64'(q4.size()), 64'd0);
        check("d2_queue_left", 64'(q2.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
